load_dispatcher: RTL and testbench

Front-end sequencer for the accelerator's parameter-load path. It accepts one load command giving word counts for input feature map, weights and bias. It then pulls exactly that many 32-bit words from a valid/ready source stream and presents each word, tagged with its destination select code, to the 1-to-3 destination demux. Phases always run in the order IFM, then WGT, then BIAS. A single done pulse marks the end of the command.

---
 rtl/load_dispatcher_if.sv | 29 ++
 rtl/load_dispatcher.sv | 125 ++++++++++++
 tb/tb_load_dispatcher.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_dispatcher_if.sv
// Handshake and command bundle between the parameter-load source, the dispatcher
// and the downstream 1-to-3 demux.
interface load_dispatcher_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) ();
  logic                  start;
  logic [CNT_WIDTH-1:0]  ifm_len;
  logic [CNT_WIDTH-1:0]  wgt_len;
  logic [CNT_WIDTH-1:0]  bias_len;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [1:0]            sel;
  logic [DATA_WIDTH-1:0] main_input;
  logic                  out_valid;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, ifm_len, wgt_len, bias_len, s_data, s_valid,
    output s_ready, sel, main_input, out_valid, busy, done
  );

  modport master (
    output start, ifm_len, wgt_len, bias_len, s_data, s_valid,
    input  s_ready, sel, main_input, out_valid, busy, done
  );
endinterface

// File: rtl/load_dispatcher.sv
// Parameter-load sequencer: pulls IFM, WGT then BIAS words from a valid/ready
// stream and presents each one, tagged with its demux select code, one cycle later.
module load_dispatcher #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  load_dispatcher_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_IFM  = 3'd1,
    LOAD_WGT  = 3'd2,
    LOAD_BIAS = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_IFM  = 2'b01;
  localparam logic [1:0] SEL_WGT  = 2'b10;
  localparam logic [1:0] SEL_BIAS = 2'b11;

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   ifm_cnt, wgt_cnt, bias_cnt;
  logic                   rdy_p0;
  logic                   accept_p0;
  logic                   last_beat_p0;
  logic [1:0]             phase_sel_p0;
  logic [1:0]             sel_p1;
  logic [DATA_WIDTH-1:0]  data_p1;
  logic                   vld_p1;

  // First phase with work left; zero-length phases are skipped in the same edge.
  function automatic state_t first_load(input logic [CNT_WIDTH-1:0] i_len,
                                        input logic [CNT_WIDTH-1:0] w_len,
                                        input logic [CNT_WIDTH-1:0] b_len);
    if (i_len != '0)      return LOAD_IFM;
    else if (w_len != '0) return LOAD_WGT;
    else if (b_len != '0) return LOAD_BIAS;
    else                  return DONE;
  endfunction

  assign rdy_p0    = (state == LOAD_IFM) || (state == LOAD_WGT) || (state == LOAD_BIAS);
  assign accept_p0 = rdy_p0 && bus.s_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    phase_sel_p0 = SEL_NONE;
    last_beat_p0 = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = first_load(bus.ifm_len, bus.wgt_len, bus.bias_len);
      end
      LOAD_IFM: begin
        phase_sel_p0 = SEL_IFM;
        last_beat_p0 = (ifm_cnt == CNT_WIDTH'(1));
        if (accept_p0 && last_beat_p0) state_nxt = first_load('0, wgt_cnt, bias_cnt);
      end
      LOAD_WGT: begin
        phase_sel_p0 = SEL_WGT;
        last_beat_p0 = (wgt_cnt == CNT_WIDTH'(1));
        if (accept_p0 && last_beat_p0) state_nxt = first_load('0, '0, bias_cnt);
      end
      LOAD_BIAS: begin
        phase_sel_p0 = SEL_BIAS;
        last_beat_p0 = (bias_cnt == CNT_WIDTH'(1));
        if (accept_p0 && last_beat_p0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Remaining-word counters: loaded on an accepted start, decremented per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifm_cnt  <= '0;
      wgt_cnt  <= '0;
      bias_cnt <= '0;
    end else if ((state == IDLE) && bus.start) begin
      ifm_cnt  <= bus.ifm_len;
      wgt_cnt  <= bus.wgt_len;
      bias_cnt <= bus.bias_len;
    end else if (accept_p0) begin
      case (state)
        LOAD_IFM:  ifm_cnt  <= ifm_cnt  - CNT_WIDTH'(1);
        LOAD_WGT:  wgt_cnt  <= wgt_cnt  - CNT_WIDTH'(1);
        LOAD_BIAS: bias_cnt <= bias_cnt - CNT_WIDTH'(1);
        default: ;
      endcase
    end
  end

  // p0 -> p1: output register toward the demux
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      sel_p1  <= SEL_NONE;
      data_p1 <= '0;
    end else begin
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        sel_p1  <= phase_sel_p0;
        data_p1 <= bus.s_data;
      end else begin
        sel_p1  <= SEL_NONE;
      end
    end
  end

  assign bus.s_ready    = rdy_p0;
  assign bus.sel        = sel_p1;
  assign bus.main_input = data_p1;
  assign bus.out_valid  = vld_p1;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_load_dispatcher.sv
// Bench for load_dispatcher: directed vector table, reset corner cases and
// randomized commands against a phase-ordering reference model.
module tb_load_dispatcher;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_dispatcher_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  load_dispatcher #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic [15:0]       li;
    logic [15:0]       lw;
    logic [15:0]       lb;
    logic [1:0]        mode;     // 0: always valid, 1: alternate, 2: random gaps
    logic [7:0]        restart;  // cycle index of a stray start pulse, 0 = none
    logic [3:0]        nexp;
    logic [0:7][31:0]  w;
    logic [0:7][1:0]   es;
    logic [0:7][31:0]  ed;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl [5];
  logic [31:0] pool_q [$];
  beat_t exp_q [$];
  logic [31:0] hold_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".s_ready"},    bus.s_ready,    0);
    check({tag, ".sel"},        bus.sel,        0);
    check({tag, ".main_input"}, bus.main_input, 0);
    check({tag, ".out_valid"},  bus.out_valid,  0);
    check({tag, ".busy"},       bus.busy,       0);
    check({tag, ".done"},       bus.done,       0);
  endtask

  // Reference: words are consumed in stream order, IFM block first, then WGT, then BIAS.
  function automatic void model_fill(input int li, input int lw, input int lb);
    int k;
    int n;
    k = 0;
    exp_q.delete();
    for (int p = 0; p < 3; p++) begin
      n = (p == 0) ? li : (p == 1) ? lw : lb;
      for (int j = 0; j < n; j++) begin
        exp_q.push_back('{sel: 2'(p + 1), data: pool_q[k]});
        k++;
      end
    end
  endfunction

  task automatic set_beat(input int r, input int k, input logic [31:0] word, input logic [1:0] s);
    tbl[r].w[k]  = word;
    tbl[r].es[k] = s;
    tbl[r].ed[k] = word;
    tbl[r].nexp  = tbl[r].nexp + 4'd1;
  endtask

  task automatic run_cmd(input int li, input int lw, input int lb, input int mode,
                         input int restart_at, input string tag);
    beat_t obs_q [$];
    int idx, cyc, done_cnt, done_cyc, post, n, budget, k;
    logic acc, sv, done_ov;
    idx = 0; cyc = 0; done_cnt = 0; done_cyc = 0; post = 0; done_ov = 1'b0;
    n = exp_q.size();
    budget = 400;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.ifm_len  = 16'(li);
    bus.wgt_len  = 16'(lw);
    bus.bias_len = 16'(lb);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, ".ready_after_start"}, bus.s_ready, (n > 0));
    check({tag, ".busy_after_start"},  bus.busy, 1);
    while (post < 2 && cyc < budget) begin
      cyc++;
      case (mode)
        0:       sv = 1'b1;
        1:       sv = ((cyc % 2) == 1);
        default: sv = ($urandom_range(0, 9) >= 3);
      endcase
      bus.s_valid = sv;
      bus.s_data  = (idx < pool_q.size()) ? pool_q[idx] : (32'hDEAD0000 + 32'(idx));
      if (cyc == restart_at) begin
        bus.start    = 1'b1;
        bus.ifm_len  = 16'd5;
        bus.wgt_len  = 16'd5;
        bus.bias_len = 16'd5;
      end
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      if (bus.out_valid) begin
        k = obs_q.size();
        if (k < n) hold_exp = exp_q[k].data;
        obs_q.push_back('{sel: bus.sel, data: bus.main_input});
      end else begin
        check({tag, ".idle_sel"},  bus.sel, 0);
        check({tag, ".hold_data"}, bus.main_input, hold_exp);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        done_ov  = bus.out_valid;
        check({tag, ".busy_in_done"}, bus.busy, 1);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (acc) idx++;
      if (done_cnt > 0) post++;
    end
    bus.s_valid = 1'b0;
    check({tag, ".beats"},    obs_q.size(), n);
    check({tag, ".consumed"}, idx, n);
    for (int i = 0; i < n; i++) begin
      if (i < obs_q.size()) begin
        check($sformatf("%s.sel%0d", tag, i),  obs_q[i].sel,  exp_q[i].sel);
        check($sformatf("%s.data%0d", tag, i), obs_q[i].data, exp_q[i].data);
      end
    end
    check({tag, ".done_count"}, done_cnt, 1);
    if (done_cnt > 0) check({tag, ".done_with_last"}, done_ov, (n > 0));
    if (mode == 0) check({tag, ".done_cycle"}, done_cyc, n + 1);
    check({tag, ".busy_end"},  bus.busy, 0);
    check({tag, ".ready_end"}, bus.s_ready, 0);
  endtask

  task automatic reset_midop();
    int acc_n, cyc;
    logic acc;
    acc_n = 0; cyc = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.ifm_len = 16'd4; bus.wgt_len = 16'd4; bus.bias_len = 16'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.s_valid = 1'b1;
    while (acc_n < 5 && cyc < 50) begin
      cyc++;
      bus.s_data = 32'd100 + 32'(acc_n);
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (acc) acc_n++;
    end
    check("midop.accepted", acc_n, 5);
    check("midop.fifth_valid", bus.out_valid, 1);
    check("midop.fifth_sel", bus.sel, 2'b10);
    check("midop.fifth_data", bus.main_input, 32'd104);
    #2 rst_n = 1'b0;
    #1 check_reset("midop_async");
    @(negedge clk);
    check_reset("midop_held");
    #2 rst_n = 1'b1;
    hold_exp = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset.out_valid", bus.out_valid, 0);
      check("post_reset.done", bus.done, 0);
      check("post_reset.s_ready", bus.s_ready, 0);
      check("post_reset.busy", bus.busy, 0);
    end
    bus.s_valid = 1'b0;
    pool_q = '{32'd7, 32'd8, 32'd9};
    exp_q.delete();
    exp_q.push_back('{sel: 2'b01, data: 32'd7});
    exp_q.push_back('{sel: 2'b10, data: 32'd8});
    exp_q.push_back('{sel: 2'b11, data: 32'd9});
    run_cmd(1, 1, 1, 0, 0, "after_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int li, lw, lb;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.ifm_len = '0; bus.wgt_len = '0; bus.bias_len = '0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hA5A5A5A5;
    hold_exp = '0;
    #2 check_reset("reset_t2");
    #5 check_reset("reset_t7");
    #5 check_reset("reset_t12");
    #6 rst_n = 1'b1;
    bus.s_valid = 1'b0;

    for (int r = 0; r < 5; r++) tbl[r] = '0;
    tbl[0].li = 2; tbl[0].lw = 3; tbl[0].lb = 1;
    set_beat(0, 0, 10, 2'b01); set_beat(0, 1, 11, 2'b01);
    set_beat(0, 2, 20, 2'b10); set_beat(0, 3, 21, 2'b10); set_beat(0, 4, 22, 2'b10);
    set_beat(0, 5, 30, 2'b11);
    tbl[1].lw = 2;
    set_beat(1, 0, 15, 2'b10); set_beat(1, 1, 90, 2'b10);
    tbl[2].li = 3; tbl[2].mode = 1;
    set_beat(2, 0, 40, 2'b01); set_beat(2, 1, 41, 2'b01); set_beat(2, 2, 42, 2'b01);
    tbl[4].li = 2; tbl[4].restart = 2;
    set_beat(4, 0, 50, 2'b01); set_beat(4, 1, 51, 2'b01);

    for (int r = 0; r < 5; r++) begin
      pool_q.delete();
      exp_q.delete();
      for (int k = 0; k < int'(tbl[r].nexp); k++) begin
        pool_q.push_back(tbl[r].w[k]);
        exp_q.push_back('{sel: tbl[r].es[k], data: tbl[r].ed[k]});
      end
      run_cmd(int'(tbl[r].li), int'(tbl[r].lw), int'(tbl[r].lb), int'(tbl[r].mode),
              int'(tbl[r].restart), $sformatf("vec%0d", r));
    end

    reset_midop();

    for (int r = 0; r < 8; r++) begin
      li = $urandom_range(0, 5);
      lw = $urandom_range(0, 5);
      lb = $urandom_range(0, 5);
      pool_q.delete();
      for (int k = 0; k < li + lw + lb; k++) pool_q.push_back($urandom);
      model_fill(li, lw, lb);
      run_cmd(li, lw, lb, 2, 0, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
